univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register for serial/parallel conversion. It supports these operations on a WIDTH-bit register:
- hold
- logical shift right/left
- rotate right/left
- arithmetic shift right
- parallel load
- synchronous clear

A shift counter tracks shifts within a frame of FRAME_LEN operations and pulses frame_done when a frame completes. The block sits between serial links and parallel datapaths as a SIPO/PISO engine.

Parameters:
- WIDTH, 8, register width in bits; legal range WIDTH >= 2
- FRAME_LEN, 8, number of shift/rotate operations per frame; legal range 1..255
- CNT_W (localparam), $clog2(FRAME_LEN+1), width of shift_cnt

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  operation enable; when 0 the register and counter hold
- mode  input  3  operation select, see Behaviour
- ser_in_r  input  1  bit inserted at MSB on logical shift right
- ser_in_l  input  1  bit inserted at LSB on logical shift left
- load_data  input  WIDTH  parallel load value
- data_out  output  WIDTH  register contents (registered)
- ser_out_r  output  1  data_out[0], combinational from the register
- ser_out_l  output  1  data_out[WIDTH-1], combinational from the register
- shift_cnt  output  CNT_W  shifts performed in the current frame, range 0..FRAME_LEN-1
- frame_done  output  1  one-cycle pulse (registered) marking frame completion

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While rst_n=0:
  - data_out=0, shift_cnt=0, frame_done=0, hence ser_out_r=ser_out_l=0.
  - Reset mid-frame discards the partial frame; no frame_done is produced.
- All state updates on the rising edge of clk; one-cycle latency from en/mode to data_out.
- en=0: data_out and shift_cnt hold; frame_done=0 on the next edge.
- en=1, operation by mode (D = data_out, W = WIDTH):
  - 000 HOLD: D unchanged
  - 001 SHR: D <= {ser_in_r, D[W-1:1]}
  - 010 SHL: D <= {D[W-2:0], ser_in_l}
  - 011 ROR: D <= {D[0], D[W-1:1]}
  - 100 ROL: D <= {D[W-2:0], D[W-1]}
  - 101 ASR: D <= {D[W-1], D[W-1:1]}
  - 110 LOAD: D <= load_data
  - 111 CLR: D <= 0
- Shift ops are modes 001..101.
- Counter, when en=1 and mode is a shift op:
  - if shift_cnt == FRAME_LEN-1: shift_cnt <= 0 and frame_done <= 1
  - otherwise shift_cnt <= shift_cnt+1 and frame_done <= 0
  - frame_done is therefore high in the cycle after the edge performing the FRAME_LEN-th shift, concurrent with shift_cnt=0 and the completed word on data_out.
- en=1, LOAD or CLR: shift_cnt <= 0, frame_done <= 0. A load when shift_cnt = FRAME_LEN-1 cancels the frame; no pulse.
- en=1, HOLD: shift_cnt holds, frame_done <= 0.
- frame_done is never high two consecutive cycles unless FRAME_LEN=1 and shifts are back-to-back. With FRAME_LEN=1 it pulses after every shift.
- Mode may change every cycle; counting spans mixed shift ops (e.g. SHR then ROL both count).
- Serial conventions:
  - SHR with ser_in_r gives LSB-first deserialisation: after WIDTH shifts the first bit is at data_out[0].
  - SHL with ser_in_l gives MSB-first deserialisation.
  - ser_out_r/ser_out_l give LSB-first/MSB-first serialisation after LOAD.
- No X propagation: unused/illegal states do not exist (all 8 mode codes defined).

Test Plan (WIDTH=8, FRAME_LEN=8):
- Reset: assert rst_n=0 asynchronously mid-cycle after loading 0xFF -> data_out=0x00, shift_cnt=0, frame_done=0 immediately, before the next clk edge.
- Shifts: LOAD 0xA5, then SHR with ser_in_r=1 -> 0xD2. LOAD 0xA5, then SHL with ser_in_l=0 -> 0x4A. LOAD 0x90, then ASR x2 -> 0xC8, 0xE4.
- Rotates: LOAD 0x81, then ROL -> 0x03. LOAD 0x81, then ROR -> 0xC0. ROR x8 from 0x81 -> 0x81 with exactly one frame_done pulse.
- Deserialise: CLR, then 8 back-to-back SHR feeding 0x3C LSB-first on ser_in_r -> data_out=0x3C and shift_cnt=0 in the same cycle, frame_done=1 for exactly one cycle. shift_cnt sequence 1..7,0 over the 8 edges.
- Gating and cancel:
  - After 5 SHR, en=0 for 3 cycles -> data_out and shift_cnt=5 unchanged; 3 more SHR -> frame_done pulses.
  - Separately, LOAD 0x55 when shift_cnt=7 -> shift_cnt=0, no frame_done.
- Serialise: LOAD 0xB4, observe ser_out_r over 8 SHR (ser_in_r=0) -> bits 0,0,1,0,1,1,0,1 and final data_out=0x00.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   Universal WIDTH-bit shift register used as a SIPO/PISO engine between
//   serial links and parallel datapaths. Supports hold, logical shift
//   right/left, rotate right/left, arithmetic shift right, parallel load and
//   synchronous clear. A frame counter tracks shift/rotate operations and
//   emits a one-cycle frame_done pulse when FRAME_LEN of them have completed.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   en         : operation enable; 0 holds register and counter
//   mode       : operation select (HOLD/SHR/SHL/ROR/ROL/ASR/LOAD/CLR)
//   ser_in_r   : bit inserted at MSB on logical shift right
//   ser_in_l   : bit inserted at LSB on logical shift left
//   load_data  : parallel load value
//   data_out   : registered register contents
//   ser_out_r  : data_out[0]
//   ser_out_l  : data_out[WIDTH-1]
//   shift_cnt  : shifts performed in the current frame (0..FRAME_LEN-1)
//   frame_done : registered one-cycle pulse marking frame completion
module univ_shift_reg #(
   parameter  int WIDTH     = 8,
   parameter  int FRAME_LEN = 8,
   localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic             ser_in_r,
   input  logic             ser_in_l,
   input  logic [WIDTH-1:0] load_data,
   output logic [WIDTH-1:0] data_out,
   output logic             ser_out_r,
   output logic             ser_out_l,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             frame_done
);

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_SHR  = 3'b001,
      OP_SHL  = 3'b010,
      OP_ROR  = 3'b011,
      OP_ROL  = 3'b100,
      OP_ASR  = 3'b101,
      OP_LOAD = 3'b110,
      OP_CLR  = 3'b111
   } op_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   op_e              op;
   logic [WIDTH-1:0] data_nxt;
   logic             is_shift;
   logic             cnt_clear;

   assign op = op_e'(mode);

   // Next register value and operation classification.
   always_comb begin
      data_nxt  = data_out;
      is_shift  = 1'b0;
      cnt_clear = 1'b0;
      unique case (op)
         OP_HOLD: data_nxt = data_out;
         OP_SHR: begin
            data_nxt = {ser_in_r, data_out[WIDTH-1:1]};
            is_shift = 1'b1;
         end
         OP_SHL: begin
            data_nxt = {data_out[WIDTH-2:0], ser_in_l};
            is_shift = 1'b1;
         end
         OP_ROR: begin
            data_nxt = {data_out[0], data_out[WIDTH-1:1]};
            is_shift = 1'b1;
         end
         OP_ROL: begin
            data_nxt = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
            is_shift = 1'b1;
         end
         OP_ASR: begin
            data_nxt = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
            is_shift = 1'b1;
         end
         OP_LOAD: begin
            data_nxt  = load_data;
            cnt_clear = 1'b1;
         end
         OP_CLR: begin
            data_nxt  = '0;
            cnt_clear = 1'b1;
         end
         default: data_nxt = data_out;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         shift_cnt  <= '0;
         frame_done <= 1'b0;
      end else if (en) begin
         data_out <= data_nxt;
         if (is_shift) begin
            // Wrap on the FRAME_LEN-th shift and flag it in the same edge.
            if (shift_cnt == CNT_LAST) begin
               shift_cnt  <= '0;
               frame_done <= 1'b1;
            end else begin
               shift_cnt  <= shift_cnt + 1'b1;
               frame_done <= 1'b0;
            end
         end else begin
            // LOAD/CLR abandon the partial frame; HOLD keeps the count.
            if (cnt_clear) begin
               shift_cnt <= '0;
            end
            frame_done <= 1'b0;
         end
      end else begin
         frame_done <= 1'b0;
      end
   end

   assign ser_out_r = data_out[0];
   assign ser_out_l = data_out[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg
//   Self-checking bench for univ_shift_reg (WIDTH=8, FRAME_LEN=8): directed
//   scenarios followed by randomized operation streams compared against an
//   integer reference model.
module tb_univ_shift_reg;

   localparam int W  = 8;
   localparam int FL = 8;
   localparam int CW = $clog2(FL + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [2:0]    mode;
   logic          ser_in_r;
   logic          ser_in_l;
   logic [W-1:0]  load_data;
   logic [W-1:0]  data_out;
   logic          ser_out_r;
   logic          ser_out_l;
   logic [CW-1:0] shift_cnt;
   logic          frame_done;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int m_d;
   int m_cnt;
   int m_fd;

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(W), .FRAME_LEN(FL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .ser_in_r  (ser_in_r),
      .ser_in_l  (ser_in_l),
      .load_data (load_data),
      .data_out  (data_out),
      .ser_out_r (ser_out_r),
      .ser_out_l (ser_out_l),
      .shift_cnt (shift_cnt),
      .frame_done(frame_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_d   = 0;
      m_cnt = 0;
      m_fd  = 0;
   endfunction

   // Arithmetic model of one clock edge.
   function automatic void model_op(input int e, input int md, input int sr,
                                    input int sl, input int ld);
      int full;
      full = 1 << W;
      if (e == 0) begin
         m_fd = 0;
         return;
      end
      case (md)
         1: m_d = (m_d / 2) + sr * (full / 2);
         2: m_d = (m_d * 2 + sl) % full;
         3: m_d = (m_d / 2) + (m_d % 2) * (full / 2);
         4: m_d = (m_d * 2) % full + (m_d / (full / 2));
         5: m_d = (m_d / 2) + ((m_d >= full / 2) ? full / 2 : 0);
         6: m_d = ld;
         7: m_d = 0;
         default: ;
      endcase
      if (md >= 1 && md <= 5) begin
         m_cnt = m_cnt + 1;
         m_fd  = (m_cnt == FL) ? 1 : 0;
         m_cnt = m_cnt % FL;
      end else begin
         if (md != 0) m_cnt = 0;
         m_fd = 0;
      end
   endfunction

   task automatic compare_all(input string tag);
      check({tag, ".data"}, 32'(data_out), 32'(m_d));
      check({tag, ".cnt"}, 32'(shift_cnt), 32'(m_cnt));
      check({tag, ".fd"}, 32'(frame_done), 32'(m_fd));
      check({tag, ".sor"}, 32'(ser_out_r), 32'(m_d % 2));
      check({tag, ".sol"}, 32'(ser_out_l), 32'(m_d / (1 << (W - 1))));
   endtask

   // Drive one operation, clock it, then compare one time unit after the edge.
   task automatic step(input int e, input int md, input int sr, input int sl,
                       input int ld, input string tag);
      en        = e[0];
      mode      = md[2:0];
      ser_in_r  = sr[0];
      ser_in_l  = sl[0];
      load_data = ld[W-1:0];
      @(posedge clk);
      model_op(e, md, sr, sl, ld);
      #1;
      compare_all(tag);
   endtask

   int          pulses;
   logic [W-1:0] pat;

   initial begin
      rst_n = 1'b0; en = 1'b0; mode = 3'd0;
      ser_in_r = 1'b0; ser_in_l = 1'b0; load_data = '0;
      model_reset();
      #12;
      compare_all("por");
      rst_n = 1'b1;

      // Asynchronous reset mid-cycle after loading 0xFF
      step(1, 6, 0, 0, 8'hFF, "ldff");
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check("areset.data", 32'(data_out), 32'h00);
      check("areset.cnt", 32'(shift_cnt), 32'h0);
      check("areset.fd", 32'(frame_done), 32'h0);
      #2 rst_n = 1'b1;

      // Shifts
      step(1, 6, 0, 0, 8'hA5, "ld_a5");
      step(1, 1, 1, 0, 0, "shr");
      check("shr_d2", 32'(data_out), 32'hD2);
      step(1, 6, 0, 0, 8'hA5, "ld_a5b");
      step(1, 2, 0, 0, 0, "shl");
      check("shl_4a", 32'(data_out), 32'h4A);
      step(1, 6, 0, 0, 8'h90, "ld_90");
      step(1, 5, 0, 0, 0, "asr1");
      check("asr_c8", 32'(data_out), 32'hC8);
      step(1, 5, 0, 0, 0, "asr2");
      check("asr_e4", 32'(data_out), 32'hE4);

      // Rotates
      step(1, 6, 0, 0, 8'h81, "ld_81");
      step(1, 4, 0, 0, 0, "rol");
      check("rol_03", 32'(data_out), 32'h03);
      step(1, 6, 0, 0, 8'h81, "ld_81b");
      step(1, 3, 0, 0, 0, "ror");
      check("ror_c0", 32'(data_out), 32'hC0);
      step(1, 6, 0, 0, 8'h81, "ld_81c");
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 3, 0, 0, 0, "ror8");
         if (frame_done) pulses++;
      end
      check("ror8_data", 32'(data_out), 32'h81);
      check("ror8_pulses", 32'(pulses), 32'd1);

      // Deserialise 0x3C LSB-first
      step(1, 7, 0, 0, 0, "clr");
      pat = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         step(1, 1, int'(pat[i]), 0, 0, "deser");
         check("deser_cnt", 32'(shift_cnt), 32'((i + 1) % 8));
      end
      check("deser_data", 32'(data_out), 32'h3C);
      check("deser_fd", 32'(frame_done), 32'h1);
      step(1, 0, 0, 0, 0, "deser_hold");
      check("deser_fd_off", 32'(frame_done), 32'h0);

      // Gating
      step(1, 6, 0, 0, 8'h00, "gate_ld");
      for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, "gate_shr");
      pat = data_out;
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 1, 8'hFF, "gate_off");
         check("gate_hold_d", 32'(data_out), 32'(pat));
         check("gate_hold_cnt", 32'(shift_cnt), 32'd5);
      end
      for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, "gate_shr2");
      check("gate_fd", 32'(frame_done), 32'h1);

      // Cancel by LOAD at shift_cnt = 7
      step(1, 7, 0, 0, 0, "cancel_clr");
      for (int i = 0; i < 7; i++) step(1, 2, 1, 1, 0, "cancel_shl");
      check("cancel_cnt7", 32'(shift_cnt), 32'd7);
      step(1, 6, 0, 0, 8'h55, "cancel_ld");
      check("cancel_cnt0", 32'(shift_cnt), 32'd0);
      check("cancel_fd", 32'(frame_done), 32'h0);

      // Serialise 0xB4 LSB-first
      step(1, 6, 0, 0, 8'hB4, "ser_ld");
      pat = 8'hB4;
      for (int i = 0; i < 8; i++) begin
         check("ser_bit", 32'(ser_out_r), 32'(pat[i]));
         step(1, 1, 0, 0, 0, "ser_shr");
      end
      check("ser_final", 32'(data_out), 32'h00);

      // Randomized streams, shift ops weighted so frames complete often
      for (int n = 0; n < 2000; n++) begin
         int md;
         md = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 5));
         step(($urandom_range(0, 7) != 0) ? 1 : 0, md, int'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), int'($urandom_range(0, 255)), "rnd");
         if ($urandom_range(0, 149) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1;
            compare_all("rnd_rst");
            #1 rst_n = 1'b1;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
